// File: rtl/msg_pkg.sv
// Shared types and defaults for the UART message assembler/disassembler pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package msg_pkg;

   // SM_TX belongs to the disassembler; the assembler uses SM_RX and SM_HOLD.
   typedef enum logic [1:0] {
      SM_RX   = 2'd0,
      SM_TX   = 2'd1,
      SM_HOLD = 2'd2
   } msg_state_e;

   localparam int DEF_WORD_SIZE        = 8;
   localparam int DEF_WORDS_PER_PACKET = 4;

endpackage

// File: rtl/msg_timeout.sv
// Idle counter: pulses expired when enabled for TIMEOUT_CYCLES clocks without a kick.
// Latency: expired is a decode of the count register and the current enable/kick.
// Backpressure: none; a kick on the terminal cycle wins over expiry.
module msg_timeout #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic n_reset,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW        = (TMO_WIDTH < 1) ? 1 : TMO_WIDTH;

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_on
         localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
         localparam logic [CW-1:0] SAT  = {CW{1'b1}};

         logic [CW-1:0] cnt_q, cnt_d;
         logic          hit;

         // Terminal-count decode and saturating next count.
         always_comb begin
            hit   = enable && !kick && (cnt_q == TERM);
            cnt_d = cnt_q;
            if (!enable || kick || hit) begin
               cnt_d = '0;
            end else if (cnt_q != SAT) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Idle count register.
         always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign expired = hit;
      end else begin : g_off
         assign expired = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/msg_asm.sv
// Packs WORDS_PER_PACKET UART words into one message, first word in the low slot.
// Latency: data_out_valid rises one clock after the strobe carrying the last word.
// Backpressure: message held until data_out_ready; words arriving meanwhile are dropped with an overrun pulse.
module msg_asm
   import msg_pkg::*;
#(
   parameter int WORD_SIZE        = DEF_WORD_SIZE,
   parameter int WORDS_PER_PACKET = DEF_WORDS_PER_PACKET,
   parameter int TIMEOUT_CYCLES   = 100000
) (
   input  logic                                  clk,
   input  logic                                  n_reset,
   input  logic [WORD_SIZE-1:0]                  data_in,
   input  logic                                  data_in_valid,
   output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out,
   output logic                                  data_out_valid,
   input  logic                                  data_out_ready,
   output logic                                  overrun,
   output logic                                  timeout
);

   localparam int CTR_WIDTH    = $clog2(WORDS_PER_PACKET);
   localparam int OUTPUT_WIDTH = WORD_SIZE * WORDS_PER_PACKET;
   localparam logic [CTR_WIDTH-1:0] LAST_SLOT = CTR_WIDTH'(WORDS_PER_PACKET - 1);

   msg_state_e               state_q, state_d;
   logic [CTR_WIDTH-1:0]     ctr_q, ctr_d;
   logic [OUTPUT_WIDTH-1:0]  data_q, data_d;
   logic                     overrun_q, overrun_d;
   logic                     timeout_q, timeout_d;
   logic                     tmo_enable;
   logic                     tmo_expired;

   // Only a partially filled message can go stale; a strobe restarts the idle count.
   assign tmo_enable = (state_q == SM_RX) && (ctr_q != '0);

   msg_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .n_reset (n_reset),
      .enable  (tmo_enable),
      .kick    (data_in_valid),
      .expired (tmo_expired)
   );

   // Next-state, slot write, and pulse generation.
   always_comb begin
      state_d   = state_q;
      ctr_d     = ctr_q;
      data_d    = data_q;
      overrun_d = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         SM_RX: begin
            if (data_in_valid) begin
               data_d[ctr_q*WORD_SIZE +: WORD_SIZE] = data_in;
               if (ctr_q == LAST_SLOT) begin
                  ctr_d   = '0;
                  state_d = SM_HOLD;
               end else begin
                  ctr_d = ctr_q + 1'b1;
               end
            end else if (tmo_expired) begin
               // Stale bits stay in data_q; the next message overwrites every slot.
               ctr_d     = '0;
               timeout_d = 1'b1;
            end
         end
         SM_HOLD: begin
            if (data_out_ready) begin
               state_d = SM_RX;
               if (data_in_valid) begin
                  // Handover and new first word in the same cycle: nothing lost.
                  data_d[WORD_SIZE-1:0] = data_in;
                  ctr_d                 = CTR_WIDTH'(1);
               end
            end else if (data_in_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = SM_RX;
            ctr_d   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= SM_RX;
         ctr_q     <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctr_q     <= ctr_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign data_out       = data_q;
   assign data_out_valid = (state_q == SM_HOLD);
   assign overrun        = overrun_q;
   assign timeout        = timeout_q;

endmodule

// File: tb/tb_msg_asm.sv
// Directed bench for msg_asm with an expected-message queue.
// Latency: checks valid exactly one clock after the last strobe.
// Backpressure: exercises held output, overrun, handover and timeout.
module tb_msg_asm;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [7:0]  data_in;
   logic        data_in_valid;
   logic [31:0] data_out;
   logic        data_out_valid;
   logic        data_out_ready;
   logic        overrun;
   logic        timeout;

   int total = 0;
   int bad   = 0;
   int ovr_cnt = 0;
   int tmo_cnt = 0;
   logic [31:0] exp_q[$];

   msg_asm #(
      .WORD_SIZE        (8),
      .WORDS_PER_PACKET (4),
      .TIMEOUT_CYCLES   (16)
   ) dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .overrun        (overrun),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   // Count one-cycle pulses seen on the opposite edge.
   always @(negedge clk) begin
      if (n_reset) begin
         if (overrun) ovr_cnt++;
         if (timeout) tmo_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] w, input logic rdy);
      data_in        = w;
      data_in_valid  = 1'b1;
      data_out_ready = rdy;
      step();
      data_in_valid  = 1'b0;
      data_out_ready = 1'b0;
   endtask

   task automatic accept();
      data_out_ready = 1'b1;
      step();
      data_out_ready = 1'b0;
   endtask

   // Wait (bounded) for a presented message and compare it with the queue head.
   task automatic wait_msg(input string tag);
      logic [31:0] e;
      int n;
      n = 0;
      while (!data_out_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, data_out_valid, 1'b1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      chk({tag, "_data"}, data_out, e);
   endtask

   initial begin
      int t0;
      n_reset        = 1'b0;
      data_in        = '0;
      data_in_valid  = 1'b0;
      data_out_ready = 1'b0;
      step();
      step();
      chk("rst_data", data_out, 32'h0);
      chk("rst_valid", data_out_valid, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      chk("rst_tmo", timeout, 1'b0);
      n_reset = 1'b1;
      step();

      // Basic assembly with gaps; valid exactly one clock after the last strobe.
      strobe(8'h11, 1'b0); step(); step();
      strobe(8'h22, 1'b0); step();
      strobe(8'h33, 1'b0); step(); step(); step();
      chk("basic_pre_valid", data_out_valid, 1'b0);
      exp_q.push_back(32'h44332211);
      strobe(8'h44, 1'b0);
      chk("basic_lat", data_out_valid, 1'b1);
      wait_msg("basic");

      // Back-pressure: held output, then a dropped word.
      repeat (20) step();
      chk("bp_held_valid", data_out_valid, 1'b1);
      strobe(8'hAA, 1'b0);
      chk("bp_ovr_pulse", overrun, 1'b1);
      step();
      chk("bp_ovr_clear", overrun, 1'b0);
      chk("bp_data_kept", data_out, 32'h44332211);
      chk("bp_still_valid", data_out_valid, 1'b1);
      chk("bp_no_tmo", tmo_cnt, 0);

      // Simultaneous accept and first word of the next message.
      strobe(8'h55, 1'b1);
      chk("sim_valid_drop", data_out_valid, 1'b0);
      strobe(8'h66, 1'b0);
      strobe(8'h77, 1'b0);
      exp_q.push_back(32'h88776655);
      strobe(8'h88, 1'b0);
      wait_msg("sim");
      chk("sim_ovr_total", ovr_cnt, 1);
      accept();
      chk("accept_valid_drop", data_out_valid, 1'b0);

      // Timeout discards a partial message.
      t0 = tmo_cnt;
      strobe(8'h01, 1'b0);
      strobe(8'h02, 1'b0);
      repeat (15) step();
      chk("tmo_not_yet", timeout, 1'b0);
      step();
      chk("tmo_pulse", timeout, 1'b1);
      step();
      chk("tmo_pulse_end", timeout, 1'b0);
      chk("tmo_once", tmo_cnt, t0 + 1);
      chk("tmo_no_valid", data_out_valid, 1'b0);
      strobe(8'hA1, 1'b0);
      strobe(8'hA2, 1'b0);
      strobe(8'hA3, 1'b0);
      exp_q.push_back(32'hA4A3A2A1);
      strobe(8'hA4, 1'b0);
      wait_msg("after_tmo");
      accept();

      // Strobe on the terminal idle cycle wins over expiry.
      t0 = tmo_cnt;
      strobe(8'h01, 1'b0);
      repeat (15) step();
      strobe(8'h02, 1'b0);
      strobe(8'h03, 1'b0);
      exp_q.push_back(32'h04030201);
      strobe(8'h04, 1'b0);
      wait_msg("tmo_edge");
      chk("tmo_edge_none", tmo_cnt, t0);
      accept();

      // Asynchronous reset mid-message.
      strobe(8'h10, 1'b0);
      strobe(8'h20, 1'b0);
      #3;
      n_reset = 1'b0;
      #1;
      chk("arst_data", data_out, 32'h0);
      chk("arst_valid", data_out_valid, 1'b0);
      chk("arst_ovr", overrun, 1'b0);
      chk("arst_tmo", timeout, 1'b0);
      step();
      n_reset = 1'b1;
      step();
      strobe(8'hB1, 1'b0);
      strobe(8'hB2, 1'b0);
      strobe(8'hB3, 1'b0);
      exp_q.push_back(32'hB4B3B2B1);
      strobe(8'hB4, 1'b0);
      wait_msg("post_rst");
      accept();
      chk("final_ovr_total", ovr_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/msg_asm.md
Name: msg_asm

Overview:
Message assembler: the receive-side counterpart of the team's UART message disassembler. Collects WORDS_PER_PACKET words from the UART receiver and packs them into one wide message for the controller. The word order matches the disassembler: the first word received lands in bits [WORD_SIZE-1:0]. A held-output handshake toward the controller, an inter-word timeout for resynchronisation, and an overrun flag make the link robust.

Parameters:
WORD_SIZE, 8, bits per UART word
WORDS_PER_PACKET, 4, words per message; minimum 2
TIMEOUT_CYCLES, 100000, idle clocks after which a partial message is discarded; 0 disables the timeout
(localparam) CTR_WIDTH = $clog2(WORDS_PER_PACKET); OUTPUT_WIDTH = WORD_SIZE*WORDS_PER_PACKET; TMO_WIDTH = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  single system clock
n_reset  in  1  asynchronous, active-low reset
data_in  in  WORD_SIZE  received word from the UART receiver
data_in_valid  in  1  one-cycle strobe; data_in is valid this cycle
data_out  out  OUTPUT_WIDTH  assembled message; stable while data_out_valid=1
data_out_valid  out  1  message complete, waiting for the controller
data_out_ready  in  1  controller accepts the message this cycle
overrun  out  1  one-cycle pulse: a word was dropped because the output was held
timeout  out  1  one-cycle pulse: a partial message was discarded

Behaviour:
- Reset: asynchronous, active-low. Clears state to SM_RX, ctr=0, the timeout counter, data_out=0, data_out_valid=0, overrun=0 and timeout=0. A reset mid-message discards all partial data.
- States (shared enum): SM_RX (collecting) and SM_HOLD (message presented).
- SM_RX, on data_in_valid: data_in is written to data_out word slot ctr, i.e. bits [(ctr+1)*WORD_SIZE-1 : ctr*WORD_SIZE], and ctr increments.
- On the word where ctr==WORDS_PER_PACKET-1: ctr returns to 0, state goes to SM_HOLD, and data_out_valid is 1 from the next cycle. Latency is one clock after the last strobe.
- SM_HOLD: data_out and data_out_valid are held.
  - data_out_ready=1 returns state to SM_RX and drops data_out_valid next cycle.
  - data_in_valid with data_out_ready=0: the word is dropped and overrun pulses for one cycle. data_out is unchanged.
  - data_in_valid and data_out_ready in the same cycle: the handover completes and the word is stored as word 0 of the next message (ctr=1, SM_RX). No drop and no overrun.
- data_out_ready in SM_RX is ignored.
- Timeout, active only when TIMEOUT_CYCLES>0:
  - The counter runs in SM_RX while ctr!=0. It clears on any data_in_valid and when ctr==0.
  - When the count reaches TIMEOUT_CYCLES-1 with no strobe that cycle: ctr←0, the counter clears, and timeout pulses one cycle. Stale data_out bits are not cleared; they are overwritten by the next message.
  - A strobe arriving on the terminal cycle takes priority: it is stored and no timeout occurs.
  - The counter saturates and never wraps.
- Outputs are registered. There is no combinational path from inputs to outputs.
- A message is delivered only when all words arrive. Partial messages are never presented.

Decomposition:
- Package msg_pkg holds:
  - the state enum (SM_RX, SM_TX, SM_HOLD as reg[1:0]), shared with the disassembler;
  - the defaults for WORD_SIZE and WORDS_PER_PACKET.
- One natural sub-module, msg_timeout. It is a parameterised idle counter with inputs clk, n_reset, enable and kick, and a one-cycle expired pulse. It is reusable by other UART-side blocks.

Test Plan:
(All scenarios use WORD_SIZE=8, WORDS_PER_PACKET=4, TIMEOUT_CYCLES=16.)
- Basic: strobe 0x11,0x22,0x33,0x44 with gaps → data_out=0x44332211, data_out_valid=1 exactly 1 clk after the 4th strobe; ready=1 → valid=0 next clk.
- Back-pressure: hold ready=0 for 20 clks after completion, strobe 0xAA → overrun 1-cycle pulse, data_out stays 0x44332211, no timeout pulse.
- Simultaneous: ready and strobe 0x55 in the same cycle while in SM_HOLD, then 0x66,0x77,0x88 → data_out=0x88776655 and overrun never pulses.
- Timeout: strobe 0x01,0x02 then idle 16 clks → timeout pulses once; then 0xA1,0xA2,0xA3,0xA4 → 0xA4A3A2A1.
- Timeout boundary: strobe 0x01 and send the 2nd strobe exactly on idle cycle 15 → no timeout; message completes normally.
- Reset mid-message: 2 words, assert n_reset asynchronously between clock edges → all outputs 0 immediately; the next 4 words assemble correctly.
